// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels between a command source and the ALU sequencer.
// The master drives commands and accepts responses; the slave is the sequencer.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 6,
  parameter int SEL_W = 4,
  parameter int RA_W  = 2
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_imm_en;
  logic [WIDTH-1:0] cmd_imm;
  logic [SEL_W-1:0] cmd_op;
  logic [RA_W-1:0]  cmd_rd;
  logic [RA_W-1:0]  cmd_rs1;
  logic [RA_W-1:0]  cmd_rs2;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [RA_W-1:0]  rsp_rd;
  logic             rsp_zero;

  modport master (
    output cmd_valid, cmd_imm_en, cmd_imm, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_rd, rsp_zero
  );

  modport slave (
    input  cmd_valid, cmd_imm_en, cmd_imm, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_rd, rsp_zero
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issues register-file operands to an external combinational ALU, writes the
// result back one cycle later and returns it on a valid/ready response channel.
module alu_cmd_sequencer #(
  parameter int WIDTH = 6,
  parameter int SEL_W = 4,
  parameter int NREG  = 4,
  parameter int RA_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_cmd_sequencer_if.slave bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [RA_W-1:0]  dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] reg_file [NREG];
  logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
  logic [SEL_W-1:0] alu_sel_reg;
  logic [RA_W-1:0]  rd_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic [RA_W-1:0]  rsp_rd_reg;

  logic             accept;
  logic             accept_imm;
  logic             accept_alu;
  logic             wr_en;
  logic [RA_W-1:0]  wr_addr;
  logic [WIDTH-1:0] wr_data;

  assign accept     = bus.cmd_valid && (state_reg == IDLE);
  assign accept_imm = accept && bus.cmd_imm_en;
  assign accept_alu = accept && !bus.cmd_imm_en;

  // One write port: immediates commit at accept, ALU results at the end of ISSUE.
  assign wr_en   = accept_imm || (state_reg == ISSUE);
  assign wr_addr = (state_reg == ISSUE) ? rd_reg : bus.cmd_rd;
  assign wr_data = (state_reg == ISSUE) ? alu_result : bus.cmd_imm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept_imm) begin
          state_next = RESP;
        end else if (accept_alu) begin
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        reg_file[i] <= '0;
      end
    end else if (wr_en) begin
      reg_file[wr_addr] <= wr_data;
    end
  end

  // Operands are sampled at accept, so rd==rs reads the pre-write value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_reg   <= '0;
      alu_b_reg   <= '0;
      alu_sel_reg <= '0;
      rd_reg      <= '0;
    end else if (accept_alu) begin
      alu_a_reg   <= reg_file[bus.cmd_rs1];
      alu_b_reg   <= reg_file[bus.cmd_rs2];
      alu_sel_reg <= bus.cmd_op;
      rd_reg      <= bus.cmd_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_reg <= '0;
      rsp_rd_reg   <= '0;
    end else if (wr_en) begin
      rsp_data_reg <= wr_data;
      rsp_rd_reg   <= wr_addr;
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_rd    = rsp_rd_reg;
  assign bus.rsp_zero  = (rsp_data_reg == '0);

  assign alu_a    = alu_a_reg;
  assign alu_b    = alu_b_reg;
  assign alu_sel  = alu_sel_reg;
  assign dbg_data = reg_file[dbg_addr];

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the 6-bit combinational ALU.
- Accepts operation commands over a valid/ready interface and holds a small register file of operands.
- Drives the ALU's A/B/select inputs from that register file, captures the ALU result one cycle later, writes it back to a destination register, and returns it on a valid/ready response channel.
- Sits between a command source (testbench or controller) and one ALU instance.

Parameters:
- WIDTH, 6, data width of operands, registers and ALU result
- SEL_W, 4, width of ALU operation select
- NREG, 4, number of register-file entries
- RA_W, 2, register address width (log2 NREG)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_imm_en  input  1  1 = load-immediate command, 0 = ALU command
- cmd_imm  input  WIDTH  immediate value, used when cmd_imm_en=1
- cmd_op  input  SEL_W  ALU operation select (0-9 defined, 10-15 pass A)
- cmd_rd  input  RA_W  destination register
- cmd_rs1  input  RA_W  source register for ALU A
- cmd_rs2  input  RA_W  source register for ALU B
- alu_a  output  WIDTH  to ALU A (registered)
- alu_b  output  WIDTH  to ALU B (registered)
- alu_sel  output  SEL_W  to ALU select (registered)
- alu_result  input  WIDTH  from ALU output (combinational path in ALU)
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_data  output  WIDTH  value written to rd
- rsp_rd  output  RA_W  destination register of this response
- rsp_zero  output  1  rsp_data == 0
- dbg_addr  input  RA_W  register-file debug read address
- dbg_data  output  WIDTH  combinational read of reg[dbg_addr]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all register-file entries=0.
  - alu_a=alu_b=0, alu_sel=0.
  - rsp_valid=0, rsp_data=0, rsp_rd=0.
  - rsp_zero=1, because it is derived from rsp_data=0.
  - cmd_ready=1 once rst_n deasserts.
- FSM states: IDLE, ISSUE, RESP.
  - cmd_ready = (state==IDLE). No command is accepted in ISSUE or RESP; cmd_valid there is ignored.
- IDLE, on accept (cmd_valid & cmd_ready at edge E0):
  - If cmd_imm_en=1: reg[cmd_rd]<=cmd_imm, rsp_data<=cmd_imm, rsp_rd<=cmd_rd, go to RESP. rsp_valid is high the cycle after E0.
  - Else: alu_a<=reg[cmd_rs1], alu_b<=reg[cmd_rs2], alu_sel<=cmd_op, latch rd internally, go to ISSUE.
- ISSUE, exactly one cycle so the ALU settles. At edge E1:
  - rsp_data<=alu_result, reg[rd]<=alu_result, rsp_rd<=rd, go to RESP.
  - ALU-command latency: accept edge to rsp_valid is 2 edges.
- RESP:
  - rsp_valid=1; rsp_data, rsp_rd and rsp_zero are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready: go to IDLE, rsp_valid<=0.
  - Minimum command spacing: 3 cycles (ALU), 2 cycles (immediate).
- alu_a/alu_b/alu_sel hold their last issued values outside ISSUE; they change only on an ALU-command accept.
- Operands are read at accept. With rd==rs1 or rd==rs2, the operand is the old value and the write occurs at E1.
- Write-back timing: the register write happens on entering RESP, independent of rsp_ready. dbg_data reflects the new value from the cycle after the write edge.
- cmd_op 10-15: forwarded unchanged; the ALU result (A) is written back. No error.
- Reset mid-operation (ISSUE or RESP): abort immediately. A write already committed at E1 persists only if E1 preceded reset; reset clears all registers anyway. No response is produced after reset.

Test Plan:
- Immediate loads: load r0=000111, then r1=010101 → each gives rsp_valid the cycle after accept, rsp_data equal to the immediate, rsp_zero=0; dbg_data(r0)=000111.
- AND/XOR: op 0000 (rs1=r0, rs2=r1, rd=r2) → alu_a=000111, alu_b=010101, rsp_data=000101 two edges after accept. Then op 0010, rd=r3 → 010010.
- Shifts and complement on r0=000111:
  - op 0011 → 111000
  - op 0110 → 001110
  - op 0111 → 100011
  - op 0101 → 000011
  - all with rd==rs1=r0 reloaded before each, confirming the old-value read.
- Backpressure: hold rsp_ready=0 for 5 cycles with cmd_valid=1 → cmd_ready=0 throughout and rsp_data stable. Release → handshake, then next command accepted in IDLE.
- Zero flag / undefined op: op 0000 with rs1=r0=000111, rs2 loaded 111000 → rsp_data=000000, rsp_zero=1. Op 1100 → rsp_data=reg[rs1].
- Reset mid-op: assert rst_n=0 during ISSUE → rsp_valid=0 and all alu_* =0 immediately. After release, dbg_data of every register = 0 and cmd_ready=1.
